// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory access stage: access sizes, FSM states,
// byte-enable constants and the captured-request record.
package dm_access_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [NUM_LANES-1:0] BE_NONE    = 4'b0000;
  localparam logic [NUM_LANES-1:0] BE_ALL     = 4'b1111;
  localparam logic [NUM_LANES-1:0] BE_LO_HALF = 4'b0011;
  localparam logic [NUM_LANES-1:0] BE_HI_HALF = 4'b1100;

  // Request fields still needed after issue, for load lane select/extension.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       uns;
    logic [1:0] addr_lo;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Data-memory request/response bus between the access stage (master) and memory (slave).
interface dm_access_unit_if #(
  parameter int DataSize = 32,
  parameter int AddrSize = 16
);
  logic                    DM_enable;
  logic                    DM_write;
  logic [AddrSize-1:0]     DM_address;
  logic [DataSize-1:0]     DM_in;
  logic [DataSize/8-1:0]   DM_byte_en;
  logic [DataSize-1:0]     DM_out;
  logic                    DM_ready;

  modport master (
    output DM_enable, DM_write, DM_address, DM_in, DM_byte_en,
    input  DM_out, DM_ready
  );

  modport slave (
    input  DM_enable, DM_write, DM_address, DM_in, DM_byte_en,
    output DM_out, DM_ready
  );
endinterface

// File: rtl/dm_access_unit_load_extend.sv
// Little-endian lane extraction plus sign/zero extension of a memory read word.
module load_extend
  import dm_access_pkg::*;
#(
  parameter int DataSize = 32
) (
  input  logic [DataSize-1:0] rdata,
  input  logic [1:0]          addr_lo,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  output logic [DataSize-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = rdata[8*addr_lo +: 8];
    h   = rdata[16*addr_lo[1] +: 16];
    ext = rdata;
    case (size)
      SZ_BYTE: ext = {{(DataSize-8){~is_unsigned & b[7]}}, b};
      SZ_HALF: ext = {{(DataSize-16){~is_unsigned & h[15]}}, h};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access stage: issues one load/store on the memory bus, stalls until
// DM_ready, then retires with a one-cycle DMout_valid. Optional: DM_MISALIGN_CHECK_EN.
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int DataSize = 32,
  parameter int AddrSize = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [AddrSize-1:0] req_addr,
  input  logic [DataSize-1:0] req_wdata,
  output logic                stall,
  output logic [DataSize-1:0] DMout,
  output logic                DMout_valid,
  dm_access_unit_if.master    dm
`ifdef DM_MISALIGN_CHECK_EN
  , output logic              misalign_err
`endif
);

  localparam int NL = DataSize/8;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic                  en_q, en_d;
  logic                  wr_q, wr_d;
  logic [AddrSize-1:0]   addr_q, addr_d;
  logic [DataSize-1:0]   din_q, din_d;
  logic [NL-1:0]         be_q, be_d;
  logic [DataSize-1:0]   dmout_q, dmout_d;
  logic                  stall_c;
  logic [DataSize-1:0]   ld_ext;
  logic [NL-1:0][7:0]    st_data;
  logic [NL-1:0]         st_be;
`ifdef DM_MISALIGN_CHECK_EN
  logic                  mis_q, mis_d;
`endif

  // Store lane steering: narrow data is replicated across lanes, enables pick the target.
  for (genvar l = 0; l < NL; l++) begin : g_lane
    localparam logic [1:0] LN = 2'(l);
    assign st_data[l] = (req_size == SZ_BYTE) ? req_wdata[7:0] :
                        (req_size == SZ_HALF) ? req_wdata[8*(l%2) +: 8] :
                                                req_wdata[8*l +: 8];
    assign st_be[l]   = (req_size == SZ_BYTE) ? (req_addr[1:0] == LN) :
                        (req_size == SZ_HALF) ? (req_addr[1] == LN[1]) :
                                                1'b1;
  end

  load_extend #(.DataSize(DataSize)) u_load_extend (
    .rdata       (dm.DM_out),
    .addr_lo     (req_q.addr_lo),
    .size        (req_q.size),
    .is_unsigned (req_q.uns),
    .ext         (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    en_d    = en_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    be_d    = be_q;
    dmout_d = dmout_q;
    stall_c = 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        stall_c = req_valid;
        if (req_valid) begin
          req_d = '{write: req_write, size: req_size, uns: req_unsigned, addr_lo: req_addr[1:0]};
`ifdef DM_MISALIGN_CHECK_EN
          if (is_misaligned(req_size, req_addr[1:0])) begin
            // Rejected without touching memory; retire with a zero result.
            mis_d   = 1'b1;
            dmout_d = '0;
            state_d = ST_RESP;
          end else
`endif
          begin
            en_d    = 1'b1;
            wr_d    = req_write;
            addr_d  = {req_addr[AddrSize-1:2], 2'b00};
            din_d   = st_data;
            be_d    = req_write ? st_be : BE_ALL;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        if (dm.DM_ready) begin
          en_d    = 1'b0;
          if (!req_q.write) dmout_d = ld_ext;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Inputs still show the retiring instruction, so nothing is accepted here.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= BE_NONE;
      dmout_q <= '0;
`ifdef DM_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
      dmout_q <= dmout_d;
`ifdef DM_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign stall         = rst & stall_c;
  assign DMout         = dmout_q;
  assign DMout_valid   = (state_q == ST_RESP);
  assign dm.DM_enable  = en_q;
  assign dm.DM_write   = wr_q;
  assign dm.DM_address = addr_q;
  assign dm.DM_in      = din_q;
  assign dm.DM_byte_en = be_q;
`ifdef DM_MISALIGN_CHECK_EN
  assign misalign_err  = mis_q & (state_q == ST_RESP);
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: loads/stores, wait states, reset abort, misalign.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall, DMout_valid;
  logic [31:0] DMout;
`ifdef DM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_chk = 0;
  int n_pass = 0;

  dm_access_unit_if #(.DataSize(32), .AddrSize(16)) dm ();

  dm_access_unit #(.DataSize(32), .AddrSize(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .DMout        (DMout),
    .DMout_valid  (DMout_valid),
    .dm           (dm)
`ifdef DM_MISALIGN_CHECK_EN
    , .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current cycle and follow it to retirement.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wd, input int waits,
                         input logic [31:0] rd, input logic [15:0] e_addr, input logic [31:0] e_din,
                         input logic [3:0] e_be, input logic [31:0] e_dmout);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; dm.DM_ready = 1'b0;
    #1 chk({tag, "_stall_c0"}, {31'b0, stall}, 32'd1);
    chk({tag, "_en_c0"}, {31'b0, dm.DM_enable}, 32'd0);
    cyc();
    for (int i = 0; i <= waits; i++) begin
      dm.DM_ready = (i == waits);
      dm.DM_out   = (i == waits) ? rd : 32'hDEADBEEF;
      #1;
      chk({tag, "_en"},    {31'b0, dm.DM_enable}, 32'd1);
      chk({tag, "_wr"},    {31'b0, dm.DM_write}, {31'b0, wr});
      chk({tag, "_addr"},  {16'b0, dm.DM_address}, {16'b0, e_addr});
      chk({tag, "_be"},    {28'b0, dm.DM_byte_en}, {28'b0, e_be});
      if (wr) chk({tag, "_din"}, dm.DM_in, e_din);
      chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
      chk({tag, "_vld_early"}, {31'b0, DMout_valid}, 32'd0);
      cyc();
    end
    dm.DM_ready = 1'b0;
    #1 chk({tag, "_vld"}, {31'b0, DMout_valid}, 32'd1);
    chk({tag, "_dmout"}, DMout, e_dmout);
    chk({tag, "_stall_resp"}, {31'b0, stall}, 32'd0);
    chk({tag, "_en_resp"}, {31'b0, dm.DM_enable}, 32'd0);
    req_valid = 1'b0;
    cyc();
  endtask

  initial begin
    dm.DM_ready = 1'b0;
    dm.DM_out   = '0;
    // Reset: outputs zero, stall suppressed even with a request showing.
    req_valid = 1'b1;
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_en", {31'b0, dm.DM_enable}, 32'd0);
    chk("rst_vld", {31'b0, DMout_valid}, 32'd0);
    chk("rst_dmout", DMout, 32'd0);
    chk("rst_addr", {16'b0, dm.DM_address}, 32'd0);
    chk("rst_be", {28'b0, dm.DM_byte_en}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    cyc();

    run_req("ldw",   1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 0, 32'h12345678, 16'h0010, 32'h0, 4'hF, 32'h12345678);
    // Back-to-back: second request in the cycle right after RESP.
    run_req("ldbs",  1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 0, 32'h80AA55CC, 16'h0010, 32'h0, 4'hF, 32'hFFFFFF80);
    run_req("ldbu",  1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 0, 32'h80AA55CC, 16'h0010, 32'h0, 4'hF, 32'h00000080);
    run_req("sth",   1'b1, 2'b01, 1'b0, 16'h0022, 32'h0000BEEF, 3, 32'h0, 16'h0020, 32'hBEEFBEEF, 4'hC, 32'h00000080);
    run_req("stb",   1'b1, 2'b00, 1'b0, 16'h0001, 32'h12345677, 1, 32'h0, 16'h0000, 32'h77777777, 4'h2, 32'h00000080);
    run_req("ldhs",  1'b0, 2'b01, 1'b0, 16'h0002, 32'h0, 2, 32'h80017FFF, 16'h0000, 32'h0, 4'hF, 32'hFFFF8001);
    run_req("ldhu",  1'b0, 2'b01, 1'b1, 16'h0000, 32'h0, 0, 32'h1234ABCD, 16'h0000, 32'h0, 4'hF, 32'h0000ABCD);
    run_req("ldbu1", 1'b0, 2'b00, 1'b1, 16'h0001, 32'h0, 0, 32'h80AA55CC, 16'h0000, 32'h0, 4'hF, 32'h00000055);
    run_req("ldw11", 1'b0, 2'b11, 1'b0, 16'h0040, 32'h0, 0, 32'hCAFEF00D, 16'h0040, 32'h0, 4'hF, 32'hCAFEF00D);
    run_req("stw",   1'b1, 2'b10, 1'b0, 16'h0044, 32'h11223344, 0, 32'h0, 16'h0044, 32'h11223344, 4'hF, 32'hCAFEF00D);

    // Stray DM_ready while idle must not move the FSM.
    dm.DM_ready = 1'b1;
    dm.DM_out   = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stray_vld", {31'b0, DMout_valid}, 32'd0);
      chk("stray_en", {31'b0, dm.DM_enable}, 32'd0);
      cyc();
    end
    dm.DM_ready = 1'b0;
    chk("stray_dmout", DMout, 32'hCAFEF00D);

    // Reset in the middle of an access aborts it.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 16'h0030;
    cyc();
    #1 chk("abort_en_before", {31'b0, dm.DM_enable}, 32'd1);
    rst = 1'b0;
    #1 chk("abort_en", {31'b0, dm.DM_enable}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_vld", {31'b0, DMout_valid}, 32'd0);
    req_valid = 1'b0;
    dm.DM_ready = 1'b1;
    cyc();
    chk("abort_vld_rst", {31'b0, DMout_valid}, 32'd0);
    @(negedge clk) rst = 1'b1;
    dm.DM_ready = 1'b0;
    cyc();
    chk("abort_vld_after", {31'b0, DMout_valid}, 32'd0);
    chk("abort_dmout", DMout, 32'd0);
    run_req("ld_post", 1'b0, 2'b10, 1'b0, 16'h0034, 32'h0, 1, 32'h5555AAAA, 16'h0034, 32'h0, 4'hF, 32'h5555AAAA);

`ifdef DM_MISALIGN_CHECK_EN
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 16'h0005;
    #1 chk("mis_stall", {31'b0, stall}, 32'd1);
    cyc();
    chk("mis_en", {31'b0, dm.DM_enable}, 32'd0);
    chk("mis_vld", {31'b0, DMout_valid}, 32'd1);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_dmout", DMout, 32'd0);
    req_valid = 1'b0;
    cyc();
    chk("mis_err_clr", {31'b0, misalign_err}, 32'd0);
    chk("mis_vld_clr", {31'b0, DMout_valid}, 32'd0);
    chk("mis_en_after", {31'b0, dm.DM_enable}, 32'd0);
    run_req("al_ldh", 1'b0, 2'b01, 1'b0, 16'h0002, 32'h0, 0, 32'hF00D1234, 16'h0000, 32'h0, 4'hF, 32'hFFFFF00D);
    #1 chk("al_err", {31'b0, misalign_err}, 32'd0);
`else
    // Without the check, offending low bits are simply ignored.
    run_req("mis_ldh", 1'b0, 2'b01, 1'b0, 16'h0003, 32'h0, 0, 32'hF00D1234, 16'h0000, 32'h0, 4'hF, 32'hFFFFF00D);
    run_req("mis_ldw", 1'b0, 2'b10, 1'b0, 16'h0005, 32'h0, 0, 32'h01020304, 16'h0004, 32'h0, 4'hF, 32'h01020304);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Data-memory access stage that sits directly upstream of the writeback select mux.
- Takes a load/store request from the execute stage: address from the ALU result, store data from the register-read value.
- Drives a variable-latency data-memory handshake and stalls the pipeline while the access is outstanding.
- Delivers the byte-lane-extracted, sign/zero-extended load value on DMout.

Parameters:
- DataSize, 32, data width; byte lanes = DataSize/8, fixed at 4 lanes.
- AddrSize, 16, byte-address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a memory instruction.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  AddrSize  byte address.
- req_wdata  in  DataSize  store data, right-justified.
- stall  out  1  upstream holds every req_* stable while high.
- DMout  out  DataSize  extended load result to the writeback mux.
- DMout_valid  out  1  one-cycle retire pulse.
- DM_enable  out  1  memory request strobe.
- DM_write  out  1  memory write.
- DM_address  out  AddrSize  word-aligned address (low 2 bits = 0).
- DM_in  out  DataSize  lane-replicated store data.
- DM_byte_en  out  4  byte write enables; 4'b1111 on loads.
- DM_out  in  DataSize  memory read data.
- DM_ready  in  1  memory completes the access this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0: DM_enable, DM_write, DM_address, DM_in, DM_byte_en, DMout, DMout_valid.
  - stall = 0 while reset is asserted.
- FSM states: IDLE, ACCESS, RESP. Encoding comes from the package.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid, register the request: DM_enable=1, DM_write=req_write, DM_address={req_addr[AddrSize-1:2],2'b00}, DM_in, DM_byte_en. Next state is ACCESS.
- ACCESS:
  - stall = 1. All DM_* outputs are held stable.
  - When DM_ready=1: DM_enable drops next cycle.
  - For a load, DMout is registered from DM_out: lane select by addr[1:0] (byte) or addr[1] (half), little-endian, then extension.
  - For a store, DMout holds its previous value.
  - Next state is RESP.
- RESP:
  - stall = 0. DMout_valid = 1 for exactly this cycle; the instruction retires.
  - req_* inputs are ignored this cycle because they still show the retiring instruction.
  - Next state is IDLE.
- Minimum latency, with the request presented in cycle 0: DM_enable is high in cycle 1. If DM_ready=1 in cycle 1, DMout_valid is high in cycle 2. Each extra wait cycle adds 1.
- Store lanes:
  - byte: DM_in = {4{wdata[7:0]}}, byte_en = 1<<addr[1:0].
  - half: DM_in = {2{wdata[15:0]}}, byte_en = addr[1] ? 1100 : 0011.
  - word: DM_in = wdata, byte_en = 1111.
- DM_ready outside ACCESS is ignored.
- Reset asserted mid-ACCESS aborts the access immediately: DM_enable drops asynchronously and no DMout_valid pulse occurs.
- Misaligned address without the feature: the offending low bits are ignored. Half uses addr[1] only; word uses lane 0.

Optional Feature:
- Macro: DM_MISALIGN_CHECK_EN.
- When defined, add output misalign_err (1 bit, reset 0).
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is not issued to memory: IDLE goes straight to RESP.
  - In that RESP cycle: DMout_valid=1, misalign_err=1, DMout=0.
  - misalign_err is 0 in all other cycles.
- When undefined: the port is absent and misaligned requests behave as described in Behaviour.

Decomposition:
- Shared package dm_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encodings ST_IDLE/ST_ACCESS/ST_RESP;
  - byte-enable constants.
- One combinational sub-module, load_extend: inputs DM_out, addr[1:0], size, unsigned; output extended data. It is reused by any future cache fill path.

Test Plan:
- Word load at addr 0x0010, DM_ready in cycle 1, DM_out=0x12345678 → DM_enable high cycle 1, DM_address=0x0010, DMout=0x12345678 with DMout_valid in cycle 2, stall high cycles 0–1.
- Signed byte load at addr 0x0013, DM_out=0x80AA55CC → DMout=0xFFFFFF80. Same with req_unsigned=1 → 0x00000080.
- Half store of 0x0000BEEF at addr 0x0022 with 3 wait cycles → DM_in=0xBEEFBEEF, DM_byte_en=1100, DM_write=1 held for 4 cycles, DMout_valid in cycle 5, DMout unchanged.
- Reset pulled low while in ACCESS → DM_enable=0 immediately, no DMout_valid; a subsequent load completes normally.
- Back-to-back loads (second req_valid in the cycle after RESP) → the second is accepted with no lost cycle. Stray DM_ready pulses in IDLE do not change state.
- With DM_MISALIGN_CHECK_EN: word load at 0x0005 → DM_enable never asserted, misalign_err=1 and DMout_valid=1 in cycle 1, DMout=0.
